// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: FIFO on a single-port synchronous SRAM with a 3-entry prefetch buffer
module sram_fifo_ctrl #(
  parameter int DW = 140,
  parameter int DD = 1024,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [AW+1:0] count,
  output logic          full,
  output logic          empty,
  output logic          ram_n_cs,
  output logic          ram_n_we,
  output logic          ram_n_oe,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  localparam logic [AW:0]   DEPTH = (AW+1)'(DD);
  localparam logic [AW-1:0] LAST  = AW'(DD - 1);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   sram_cnt_q, sram_cnt_d;
  logic          inflight_q, inflight_d, prio_rd_q, prio_rd_d;
  logic [DW-1:0] ob_q [3];
  logic [DW-1:0] ob_d [3];
  logic [1:0]    ob_head_q, ob_head_d, ob_tail_q, ob_tail_d, ob_cnt_q, ob_cnt_d;
  logic          not_full, rd_req, wr_req, gnt_rd, gnt_wr, pop;
  assign ram_n_oe = 1'b0;
  assign ram_din  = wr_data;
  assign rd_data  = ob_q[ob_head_q];
  always_comb begin
    not_full   = sram_cnt_q != DEPTH;
    // the read credit counts the in-flight word so the prefetch buffer never overflows
    rd_req     = n_rst && (sram_cnt_q != '0) && (({1'b0, ob_cnt_q} + {2'b0, inflight_q}) < 3'd3);
    wr_req     = n_rst && wr_valid && not_full;
    gnt_rd     = rd_req && (prio_rd_q || !wr_req);
    gnt_wr     = wr_req && !gnt_rd;
    rd_valid   = n_rst && (ob_cnt_q != 2'd0);
    pop        = rd_valid && rd_ready;
    wr_ready   = n_rst && not_full && !(rd_req && prio_rd_q);
    full       = n_rst && !not_full;
    count      = n_rst ? ({1'b0, sram_cnt_q} + (AW+2)'(inflight_q) + (AW+2)'(ob_cnt_q)) : '0;
    empty      = count == '0;
    ram_n_cs   = !(gnt_rd || gnt_wr);
    ram_n_we   = !gnt_wr;
    ram_ad     = gnt_wr ? wr_ptr_q : gnt_rd ? rd_ptr_q : '0;
    prio_rd_d  = prio_rd_q ^ (rd_req && wr_req);
    inflight_d = gnt_rd;
    sram_cnt_d = sram_cnt_q + (AW+1)'(gnt_wr) - (AW+1)'(gnt_rd);
    wr_ptr_d   = gnt_wr ? ((wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d   = gnt_rd ? ((rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1)) : rd_ptr_q;
    ob_d       = ob_q;
    if (inflight_q) ob_d[ob_tail_q] = ram_dout;
    ob_tail_d  = inflight_q ? ((ob_tail_q == 2'd2) ? 2'd0 : ob_tail_q + 2'd1) : ob_tail_q;
    ob_head_d  = pop ? ((ob_head_q == 2'd2) ? 2'd0 : ob_head_q + 2'd1) : ob_head_q;
    ob_cnt_d   = ob_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      inflight_q <= 1'b0;
      prio_rd_q  <= 1'b0;
      ob_q       <= '{default: '0};
      ob_head_q  <= '0;
      ob_tail_q  <= '0;
      ob_cnt_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= inflight_d;
      prio_rd_q  <= prio_rd_d;
      ob_q       <= ob_d;
      ob_head_q  <= ob_head_d;
      ob_tail_q  <= ob_tail_d;
      ob_cnt_q   <= ob_cnt_d;
    end
  end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: scoreboard bench for sram_fifo_ctrl with a behavioural single-port SRAM
module tb_sram_fifo_ctrl;
  localparam int DW = 16, DD = 4, AW = 3;
  logic clk = 0, n_rst = 0, wr_valid = 0, rd_ready = 0;
  logic [DW-1:0] wr_data = '0, rd_data, ram_din, ram_dout = '0;
  logic wr_ready, rd_valid, full, empty, ram_n_cs, ram_n_we, ram_n_oe;
  logic [AW+1:0] count;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] mem [DD];
  logic [DW-1:0] sb [$];
  logic push_acc = 0, pop_acc = 0, rd_grant = 0, sb_under = 0;
  logic [DW-1:0] pop_data = '0, pop_exp = '0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.DW(DW), .DD(DD), .AW(AW)) dut (
    .clk(clk), .n_rst(n_rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .count(count),
    .full(full), .empty(empty), .ram_n_cs(ram_n_cs), .ram_n_we(ram_n_we),
    .ram_n_oe(ram_n_oe), .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // out-of-range or idle accesses return junk so stray captures show up as bad data
  always @(posedge clk) begin
    if (!ram_n_cs && !ram_n_we && int'(ram_ad) < DD) mem[ram_ad[1:0]] <= ram_din;
    ram_dout <= (!ram_n_cs && ram_n_we && int'(ram_ad) < DD) ? mem[ram_ad[1:0]] : DW'($urandom);
  end

  task automatic tick();
    @(negedge clk);
    push_acc = wr_valid && wr_ready;
    pop_acc  = rd_valid && rd_ready;
    rd_grant = !ram_n_cs && ram_n_we;
    pop_data = rd_data;
    if (push_acc) sb.push_back(wr_data);
    if (pop_acc) begin
      sb_under = sb.size() == 0;
      pop_exp  = sb_under ? '0 : sb.pop_front();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 0; wr_valid = 0; rd_ready = 0;
    @(posedge clk); #1;
    n_rst = 1;
    sb.delete();
  endtask

  task automatic test_reset();
    n_rst = 0; wr_valid = 1; rd_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wr_ready, rd_valid, ram_n_cs, ram_n_we, ram_n_oe, empty, full} !== 7'b0011010) begin
      errors++; $display("FAIL reset_flags got=%b exp=0011010", {wr_ready, rd_valid, ram_n_cs, ram_n_we, ram_n_oe, empty, full});
    end
    checks++;
    if (count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++;
    if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    n_rst = 1; wr_valid = 0; rd_ready = 0;
    sb.delete();
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_release_wr_ready got=%b exp=1", wr_ready); end
  endtask

  task automatic test_latency();
    wr_valid = 1; wr_data = 16'h1; #1;
    checks++;
    if ({ram_n_cs, ram_n_we, ram_ad} !== {2'b00, 3'd0}) begin
      errors++; $display("FAIL lat_c0_write got cs=%b we=%b ad=%0d exp cs=0 we=0 ad=0", ram_n_cs, ram_n_we, ram_ad);
    end
    tick();
    wr_valid = 0; #1;
    checks++;
    if ({ram_n_cs, ram_n_we, ram_ad} !== {2'b01, 3'd0}) begin
      errors++; $display("FAIL lat_c1_read got cs=%b we=%b ad=%0d exp cs=0 we=1 ad=0", ram_n_cs, ram_n_we, ram_ad);
    end
    checks++;
    if ({rd_valid, count} !== {1'b0, 5'd1}) begin errors++; $display("FAIL lat_c1 got valid=%b count=%0d exp valid=0 count=1", rd_valid, count); end
    tick();
    checks++;
    if ({rd_valid, count} !== {1'b0, 5'd1}) begin errors++; $display("FAIL lat_c2 got valid=%b count=%0d exp valid=0 count=1", rd_valid, count); end
    tick();
    checks++;
    if ({rd_valid, rd_data, count} !== {1'b1, 16'h1, 5'd1}) begin
      errors++; $display("FAIL lat_c3 got valid=%b data=%h count=%0d exp valid=1 data=0001 count=1", rd_valid, rd_data, count);
    end
    rd_ready = 1;
    tick();
    rd_ready = 0;
    checks++;
    if (!pop_acc || sb_under || pop_data !== pop_exp) begin
      errors++; $display("FAIL lat_pop got acc=%b data=%h exp acc=1 data=%h", pop_acc, pop_data, pop_exp);
    end
    checks++;
    if ({empty, count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL lat_empty got empty=%b count=%0d exp empty=1 count=0", empty, count); end
  endtask

  task automatic test_fill();
    int n = 0, guard = 0, held = 0;
    do_reset();
    wr_valid = 1;
    while (n < 7 && guard < 40) begin
      wr_data = DW'(n);
      tick();
      if (push_acc) n++;
      guard++;
    end
    wr_data = 16'h7;
    checks++;
    if (n != 7) begin errors++; $display("FAIL fill_accepts got=%0d exp=7", n); end
    checks++;
    if ({full, wr_ready, count} !== {1'b1, 1'b0, 5'd7}) begin
      errors++; $display("FAIL fill_full got full=%b wr_ready=%b count=%0d exp full=1 wr_ready=0 count=7", full, wr_ready, count);
    end
    repeat (4) begin tick(); if (push_acc) held++; end
    checks++;
    if (held != 0 || count !== 5'd7) begin errors++; $display("FAIL fill_eighth_held got accepts=%0d count=%0d exp accepts=0 count=7", held, count); end
    wr_valid = 0;
  endtask

  task automatic test_drain();
    int n = 0, guard = 0;
    rd_ready = 1;
    while (n < 7 && guard < 40) begin
      tick();
      if (pop_acc) begin
        checks++;
        if (sb_under || pop_data !== pop_exp || pop_data !== DW'(n)) begin
          errors++; $display("FAIL drain_data idx=%0d got=%h exp=%h", n, pop_data, DW'(n));
        end
        n++;
      end
      guard++;
    end
    rd_ready = 0;
    checks++;
    if (n != 7) begin errors++; $display("FAIL drain_pops got=%0d exp=7", n); end
    checks++;
    if ({empty, rd_valid, count} !== {1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL drain_empty got empty=%b valid=%b count=%0d exp empty=1 valid=0 count=0", empty, rd_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    int pushes = 0, pops = 0, guard = 0;
    logic [DW-1:0] d = 16'h100;
    logic prev_we = 0;
    wr_valid = 1; rd_ready = 1;
    for (int c = 0; c < 60; c++) begin
      wr_data = d; #1;
      if (c >= 10) begin
        checks++;
        if (ram_n_cs !== 1'b0 || ram_n_we === prev_we) begin
          errors++; $display("FAIL b2b_alternate cyc=%0d got cs=%b we=%b prev_we=%b exp cs=0 we=%b", c, ram_n_cs, ram_n_we, prev_we, !prev_we);
        end
      end
      prev_we = ram_n_we;
      tick();
      if (push_acc) begin d++; pushes++; end
      if (pop_acc) begin
        pops++;
        checks++;
        if (sb_under || pop_data !== pop_exp) begin errors++; $display("FAIL b2b_data got=%h exp=%h", pop_data, pop_exp); end
      end
    end
    checks++;
    if (pushes < 25 || pops < 20) begin errors++; $display("FAIL b2b_rate got pushes=%0d pops=%0d exp pushes>=25 pops>=20", pushes, pops); end
    wr_valid = 0;
    while (sb.size() != 0 && guard < 40) begin
      tick();
      if (pop_acc) begin
        checks++;
        if (sb_under || pop_data !== pop_exp) begin errors++; $display("FAIL b2b_drain got=%h exp=%h", pop_data, pop_exp); end
      end
      guard++;
    end
    rd_ready = 0;
    checks++;
    if (sb.size() != 0 || empty !== 1'b1) begin errors++; $display("FAIL b2b_end got left=%0d empty=%b exp left=0 empty=1", sb.size(), empty); end
  endtask

  task automatic test_mid_reset();
    int n = 0, reads = 0, guard = 0;
    do_reset();
    wr_valid = 1;
    while (n < 3 && guard < 20) begin
      wr_data = DW'(16'h50 + n);
      tick();
      if (rd_grant) reads++;
      if (push_acc) n++;
      guard++;
    end
    wr_valid = 0;
    while (reads < 3 && guard < 40) begin
      tick();
      if (rd_grant) reads++;
      guard++;
    end
    checks++;
    if (reads != 3 || {rd_valid, count} !== {1'b1, 5'd3}) begin
      errors++; $display("FAIL mr_setup got reads=%0d valid=%b count=%0d exp reads=3 valid=1 count=3", reads, rd_valid, count);
    end
    n_rst = 0; #1;
    checks++;
    if ({rd_valid, count} !== {1'b0, 5'd0}) begin errors++; $display("FAIL mr_during got valid=%b count=%0d exp valid=0 count=0", rd_valid, count); end
    tick();
    n_rst = 1;
    sb.delete();
    #1;
    checks++;
    if ({rd_valid, count, empty} !== {1'b0, 5'd0, 1'b1}) begin
      errors++; $display("FAIL mr_after got valid=%b count=%0d empty=%b exp valid=0 count=0 empty=1", rd_valid, count, empty);
    end
    wr_valid = 1; wr_data = 16'hAB; #1;
    checks++;
    if ({ram_n_cs, ram_n_we, ram_ad} !== {2'b00, 3'd0}) begin
      errors++; $display("FAIL mr_write_addr got cs=%b we=%b ad=%0d exp cs=0 we=0 ad=0", ram_n_cs, ram_n_we, ram_ad);
    end
    tick();
    wr_valid = 0; rd_ready = 1; n = 0; guard = 0;
    while (guard < 12) begin
      tick();
      if (pop_acc) begin
        n++;
        checks++;
        if (sb_under || pop_data !== 16'hAB) begin errors++; $display("FAIL mr_word got=%h exp=00ab", pop_data); end
      end
      guard++;
    end
    rd_ready = 0;
    checks++;
    if (n != 1 || empty !== 1'b1) begin errors++; $display("FAIL mr_only_word got pops=%0d empty=%b exp pops=1 empty=1", n, empty); end
  endtask

  task automatic test_random();
    int pw, pr;
    for (int c = 0; c < 10000; c++) begin
      pw = ((c / 500) % 2) ? 85 : 25;
      pr = ((c / 500) % 2) ? 25 : 85;
      wr_valid = $urandom_range(0, 99) < pw;
      rd_ready = $urandom_range(0, 99) < pr;
      wr_data  = DW'($urandom);
      tick();
      if (pop_acc) begin
        checks++;
        if (sb_under || pop_data !== pop_exp) begin errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, pop_data, pop_exp); end
      end
      checks++;
      if (int'(count) != sb.size() || empty !== (sb.size() == 0)) begin
        errors++; $display("FAIL rand_count cyc=%0d got count=%0d empty=%b exp count=%0d", c, count, empty, sb.size());
      end
    end
    wr_valid = 0; rd_ready = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_latency();
    test_fill();
    test_drain();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
